// File: rtl/buf_seq_ctrl_pkg.sv
// Shared types and defaults for the vector-buffer sequencer.
package buf_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    localparam int ARR_DEPTH_DEF  = 16;
    localparam int PASS_WIDTH_DEF = 8;

endpackage

// File: rtl/buf_seq_ctrl.sv
// Loads a vector buffer from a valid/ready stream, then replays it num_pass times; 1 write or read per cycle, no bubble.
// Upstream stalls on i_wr_valid=0 and consumer stalls on i_rd_ready=0 hold addresses and flags.
module buf_seq_ctrl
    import buf_seq_ctrl_pkg::*;
#(
    parameter int ARR_DEPTH  = ARR_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_vec,
    input  logic [PASS_WIDTH-1:0] i_num_pass,
    input  logic                  i_clr,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic                  o_buf_we,
    output logic [ADDR_WIDTH-1:0] o_buf_addr_wr,
    output logic [ADDR_WIDTH-1:0] o_buf_addr_rd,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic                  o_rd_last,
    output logic [PASS_WIDTH-1:0] o_pass_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = ADDR_WIDTH + 1;

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [CW-1:0]         r_wr_cnt;
    logic [CW-1:0]         r_rd_cnt;
    logic [CW-1:0]         r_num_vec;
    logic [PASS_WIDTH-1:0] r_pass_cnt;
    logic [PASS_WIDTH-1:0] r_num_pass;

    logic w_start_ok;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_wr_last;
    logic w_rd_last;
    logic w_pass_last;

    assign w_start_ok  = i_start && (i_num_vec != '0) && (i_num_vec <= CW'(ARR_DEPTH));
    assign w_wr_hs     = (r_state == S_LOAD) && i_wr_valid;
    assign w_rd_hs     = (r_state == S_STREAM) && i_rd_ready;
    assign w_wr_last   = (r_wr_cnt == r_num_vec - CW'(1));
    assign w_rd_last   = (r_state == S_STREAM) && (r_rd_cnt == r_num_vec - CW'(1));
    assign w_pass_last = (r_pass_cnt == r_num_pass - PASS_WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_state_nxt = S_LOAD;
            S_LOAD:   if (w_wr_hs && w_wr_last) w_state_nxt = S_STREAM;
            S_STREAM: if (w_rd_hs && w_rd_last && w_pass_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (i_clr) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters are zeroed on abort and on completion so IDLE always shows address 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pass_cnt <= '0;
            r_num_vec  <= '0;
            r_num_pass <= '0;
        end else if (i_clr || (r_state == S_DONE)) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pass_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_num_vec  <= i_num_vec;
                        r_num_pass <= (i_num_pass == '0) ? PASS_WIDTH'(1) : i_num_pass;
                        r_wr_cnt   <= '0;
                        r_rd_cnt   <= '0;
                        r_pass_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_wr_hs) r_wr_cnt <= r_wr_cnt + CW'(1);
                end
                S_STREAM: begin
                    if (w_rd_hs) begin
                        if (w_rd_last) begin
                            r_rd_cnt   <= '0;
                            r_pass_cnt <= r_pass_cnt + PASS_WIDTH'(1);
                        end else begin
                            r_rd_cnt <= r_rd_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wr_ready    = (r_state == S_LOAD);
    assign o_buf_we      = i_wr_valid && o_wr_ready;
    assign o_buf_addr_wr = r_wr_cnt[ADDR_WIDTH-1:0];
    assign o_buf_addr_rd = r_rd_cnt[ADDR_WIDTH-1:0];
    assign o_rd_valid    = (r_state == S_STREAM);
    assign o_rd_last     = w_rd_last;
    assign o_pass_idx    = r_pass_cnt;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_buf_seq_ctrl.sv
// Directed bench for buf_seq_ctrl with a behavioural vector buffer for end-to-end data checks.
module tb_buf_seq_ctrl;

    localparam int AW = 4;
    localparam int PW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_num_vec = '0;
    logic [PW-1:0] i_num_pass = '0;
    logic          i_clr = 1'b0;
    logic          i_wr_valid = 1'b0;
    logic          i_rd_ready = 1'b0;
    logic          o_wr_ready, o_buf_we, o_rd_valid, o_rd_last, o_busy, o_done;
    logic [AW-1:0] o_buf_addr_wr, o_buf_addr_rd;
    logic [PW-1:0] o_pass_idx;

    logic [31:0] wr_dat = '0;
    logic [31:0] mem [16];
    logic [31:0] expd [16];

    int errs = 0;
    int checks = 0;

    buf_seq_ctrl u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_vec(i_num_vec),
        .i_num_pass(i_num_pass), .i_clr(i_clr), .i_wr_valid(i_wr_valid),
        .o_wr_ready(o_wr_ready), .o_buf_we(o_buf_we), .o_buf_addr_wr(o_buf_addr_wr),
        .o_buf_addr_rd(o_buf_addr_rd), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_rd_last(o_rd_last), .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_buf_we) mem[o_buf_addr_wr] <= wr_dat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " busy"},   32'(o_busy), 0);
        chk({tag, " wr_rdy"}, 32'(o_wr_ready), 0);
        chk({tag, " we"},     32'(o_buf_we), 0);
        chk({tag, " awr"},    32'(o_buf_addr_wr), 0);
        chk({tag, " ard"},    32'(o_buf_addr_rd), 0);
        chk({tag, " rvld"},   32'(o_rd_valid), 0);
        chk({tag, " rlast"},  32'(o_rd_last), 0);
        chk({tag, " pass"},   32'(o_pass_idx), 0);
        chk({tag, " done"},   32'(o_done), 0);
    endtask

    task automatic start_job(input int nv, input int np);
        i_num_vec  = (AW+1)'(nv);
        i_num_pass = PW'(np);
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
    endtask

    initial begin
        int nw, nr, k;
        bit got_done;

        // Reset state
        #12;
        chk_idle_outs("rst");
        i_rst_n = 1'b1;
        step();

        // Basic job: 4 vectors, 3 passes, no stalls; done in cycle 17 after start edge
        i_wr_valid = 1'b1;
        i_rd_ready = 1'b1;
        start_job(4, 3);
        for (int c = 1; c <= 18; c++) begin
            wr_dat = 32'hA000 + 32'(c);
            #1;
            if (c <= 4) begin
                chk("t1 we", 32'(o_buf_we), 1);
                chk("t1 awr", 32'(o_buf_addr_wr), 32'(c - 1));
                expd[c-1] = wr_dat;
            end else if (c <= 16) begin
                k = c - 5;
                chk("t1 rvld", 32'(o_rd_valid), 1);
                chk("t1 ard", 32'(o_buf_addr_rd), 32'(k % 4));
                chk("t1 rlast", 32'(o_rd_last), 32'((k % 4) == 3));
                chk("t1 pass", 32'(o_pass_idx), 32'(k / 4));
                chk("t1 data", mem[o_buf_addr_rd], expd[k % 4]);
            end
            chk("t1 done", 32'(o_done), 32'(c == 17));
            if (c == 18) chk("t1 busy end", 32'(o_busy), 0);
            step();
        end

        // Illegal vector counts are ignored
        start_job(0, 1);
        #1;
        chk("t3 nv0 busy", 32'(o_busy), 0);
        chk("t3 nv0 we", 32'(o_buf_we), 0);
        start_job(17, 1);
        #1;
        chk("t3 nv17 busy", 32'(o_busy), 0);
        chk("t3 nv17 we", 32'(o_buf_we), 0);
        step();

        // Abort on the second read of pass 1 (cycle 10), then a clean 2-vector job
        start_job(4, 3);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) begin
                i_clr = 1'b1;
                #1;
                chk("t4 pre pass", 32'(o_pass_idx), 1);
                chk("t4 pre ard", 32'(o_buf_addr_rd), 1);
            end
            step();
        end
        i_clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_idle_outs("t4 clr");
            step();
        end
        start_job(2, 1);
        for (int c = 1; c <= 5; c++) begin
            wr_dat = 32'hB000 + 32'(c);
            #1;
            if (c <= 2) begin
                chk("t4b awr", 32'(o_buf_addr_wr), 32'(c - 1));
                expd[c-1] = wr_dat;
            end else if (c <= 4) begin
                chk("t4b ard", 32'(o_buf_addr_rd), 32'(c - 3));
                chk("t4b rlast", 32'(o_rd_last), 32'(c == 4));
                chk("t4b data", mem[o_buf_addr_rd], expd[c-3]);
            end
            chk("t4b done", 32'(o_done), 32'(c == 5));
            step();
        end

        // Consumer stall of 5 cycles on last vector of last pass
        start_job(2, 2);
        for (int c = 1; c <= 12; c++) begin
            i_rd_ready = !(c >= 6 && c <= 10);
            #1;
            if (c >= 6 && c <= 11) begin
                chk("t5 ard", 32'(o_buf_addr_rd), 1);
                chk("t5 rlast", 32'(o_rd_last), 1);
                chk("t5 rvld", 32'(o_rd_valid), 1);
                chk("t5 pass", 32'(o_pass_idx), 1);
            end
            chk("t5 done", 32'(o_done), 32'(c == 12));
            step();
        end

        // Full depth, pass count 0 treated as 1, random gaps on both sides
        nw = 0;
        nr = 0;
        got_done = 0;
        start_job(16, 0);
        for (int c = 0; c < 600 && !got_done; c++) begin
            i_wr_valid = 1'($urandom_range(0, 1));
            i_rd_ready = 1'($urandom_range(0, 1));
            wr_dat = $urandom;
            #1;
            if (o_buf_we) begin
                chk("t2 awr", 32'(o_buf_addr_wr), 32'(nw % 16));
                expd[nw % 16] = wr_dat;
                nw++;
            end
            if (o_rd_valid && i_rd_ready) begin
                chk("t2 ard", 32'(o_buf_addr_rd), 32'(nr % 16));
                chk("t2 data", mem[o_buf_addr_rd], expd[nr % 16]);
                chk("t2 rlast", 32'(o_rd_last), 32'(nr == 15));
                nr++;
            end
            if (o_done) got_done = 1;
            step();
        end
        chk("t2 done seen", 32'(got_done), 1);
        chk("t2 writes", 32'(nw), 16);
        chk("t2 reads", 32'(nr), 16);

        // Async reset mid-LOAD after two writes
        i_wr_valid = 1'b1;
        i_rd_ready = 1'b1;
        start_job(4, 1);
        step();
        step();
        #1;
        chk("t6 pre awr", 32'(o_buf_addr_wr), 2);
        i_rst_n = 1'b0;
        #1;
        chk_idle_outs("t6 rst");
        i_start   = 1'b1;
        i_num_vec = 5'd4;
        step();
        chk("t6 start in rst", 32'(o_busy), 0);
        i_start = 1'b0;
        i_rst_n = 1'b1;
        step();
        chk("t6 after rst", 32'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
